// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ requesters.
// Each grant covers a burst of up to BURST_MAX beats, and writes stall while the FIFO is full or almost full.
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH       = 8,
   parameter int NUM_REQ          = 4,
   parameter int BURST_MAX        = 4,
   parameter int FIFO_DEPTH_WIDTH = 5,
   parameter int AFULL_THRESH     = 30
) (
   input  logic                          clk_wr,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            ack,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          wr,
   output logic [DATA_WIDTH-1:0]         in_data,
   input  logic                          full,
   input  logic [FIFO_DEPTH_WIDTH-1:0]   data_count_w,
   output logic                          busy,
   output logic [15:0]                   beat_count
);
   localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BEAT_W = $clog2(BURST_MAX + 1);
   localparam int THR_W  = FIFO_DEPTH_WIDTH + 1;
   localparam logic [PTR_W-1:0]  LAST_REQ  = PTR_W'(NUM_REQ - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_MAX - 1);
   localparam logic [THR_W-1:0]  THRESH    = THR_W'(AFULL_THRESH);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;

   logic [0:0]         state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   owner;
   logic [BEAT_W-1:0]  beats;
   logic               stall;
   logic               owner_req;
   logic               release_now;
   logic [PTR_W-1:0]   next_ptr;
   logic [PTR_W-1:0]   pick;
   logic [NUM_REQ-1:0] pick_onehot;

   // The threshold compare is one bit wider so a threshold equal to the FIFO depth still fits.
   assign stall       = full | ({1'b0, data_count_w} >= THRESH);
   assign owner_req   = req[owner];
   assign busy        = (state == BURST);
   assign wr          = busy & owner_req & ~stall;
   assign release_now = busy & (~owner_req | (wr & (beats == LAST_BEAT)));
   assign next_ptr    = (owner == LAST_REQ) ? '0 : owner + PTR_W'(1);

   always_comb begin
      ack     = '0;
      in_data = '0;
      if (wr) ack[owner] = 1'b1;
      if (busy) in_data = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
   end

   // Scan from the highest offset down so the lowest offset from rr_ptr wins.
   always_comb begin
      int idx;
      idx         = 0;
      pick        = rr_ptr;
      pick_onehot = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (req[idx]) pick = PTR_W'(idx);
      end
      pick_onehot[pick] = 1'b1;
   end

   always_ff @(posedge clk_wr) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= '0;
         rr_ptr     <= '0;
         owner      <= '0;
         beats      <= '0;
         beat_count <= '0;
      end else begin
         if (wr) begin
            beats      <= beats + BEAT_W'(1);
            beat_count <= beat_count + 16'd1;
         end
         case (state)
            IDLE: begin
               if (|req) begin
                  state <= BURST;
                  grant <= pick_onehot;
                  owner <= pick;
                  beats <= '0;
               end
            end
            BURST: begin
               if (release_now) begin
                  state  <= IDLE;
                  grant  <= '0;
                  rr_ptr <= next_ptr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each requester word and of the FIFO write data.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the FIFO write port.
REQ-003 SHALL have parameter BURST_MAX, default 4, maximum beats per grant.
REQ-004 SHALL have parameter FIFO_DEPTH_WIDTH, default 5, width of the FIFO write-side data count.
REQ-005 SHALL have parameter AFULL_THRESH, default 30, data_count_w value at or above which writes stall.
REQ-006 SHALL have port clk_wr, input, 1, single clock (FIFO write clock); one clock, reset synchronous and active-high.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port req, input, NUM_REQ, per-requester valid.
REQ-009 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH, requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port ack, output, NUM_REQ, one-hot; requester i word written this cycle.
REQ-011 SHALL have port grant, output, NUM_REQ, registered one-hot current owner, zero when idle.
REQ-012 SHALL have port wr, output, 1, FIFO write enable.
REQ-013 SHALL have port in_data, output, DATA_WIDTH, FIFO write data.
REQ-014 SHALL have port full, input, 1, FIFO full flag.
REQ-015 SHALL have port data_count_w, input, FIFO_DEPTH_WIDTH, FIFO write-side occupancy.
REQ-016 SHALL have port busy, output, 1, high while in BURST.
REQ-017 SHALL have port beat_count, output, 16, total beats written, wraps 0xFFFF->0.

Function
REQ-018 SHALL implement FSM states IDLE and BURST, plus registers rr_ptr (log2 NUM_REQ bits), owner, and beats (0..BURST_MAX).
REQ-019 In IDLE with any req high, SHALL pick the first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ; load grant=onehot(i), beats=0, enter BURST next cycle.
REQ-020 In IDLE with req=0, SHALL remain in IDLE with grant=0.
REQ-021 stall SHALL be full | (data_count_w >= AFULL_THRESH), combinational.
REQ-022 wr and ack[owner] SHALL be combinational: high iff state=BURST & req[owner] & ~stall; all other ack bits 0.
REQ-023 in_data SHALL equal req_data word of owner while in BURST, else 0.
REQ-024 Each cycle with wr=1, beats SHALL increment and beat_count SHALL increment by 1 (mod 2^16).
REQ-025 BURST SHALL release (grant<=0, rr_ptr<=owner+1 mod NUM_REQ, state<=IDLE) when req[owner]=0, or when wr=1 and beats+1=BURST_MAX.
REQ-026 stall SHALL NOT release the grant; owner is held, beats unchanged, while req[owner] stays high.
REQ-027 Requester word SHALL be held stable by the requester until ack; arbiter never writes without req[owner]=1.
REQ-028 Minimum latency: req rise in IDLE -> grant next cycle -> first wr same cycle as grant (if no stall).
REQ-029 One IDLE cycle SHALL separate consecutive bursts, including back-to-back re-grant to the same requester.
REQ-030 Requests arriving for non-owners during BURST SHALL be ignored until IDLE.

Reset
REQ-031 While rst=1 at a clk_wr edge: state=IDLE, grant=0, rr_ptr=0, beats=0, beat_count=0; hence wr=0, ack=0, in_data=0, busy=0 the following cycle.
REQ-032 Reset mid-burst SHALL abandon the burst with no further write; arbitration restarts from requester 0.

Verification
REQ-033 Single requester: req[0] held, data 0..9 supplied on ack, full=0, data_count_w=0 -> FIFO receives 0..9 in order in bursts of 4,4,2 separated by one idle cycle; beat_count=10.
REQ-034 Fairness: req=4'b1111 held, no stall -> grant sequence 0001,0010,0100,1000,0001, each 4 wr pulses, one idle cycle between.
REQ-035 Stall: full=1 for 3 cycles after second beat of requester 2 -> wr=0, ack=0, grant=0100 held, beats stays 2; 2 more beats after full drops, then release, rr_ptr=3.
REQ-036 Almost-full: full=0, data_count_w=30 -> wr=0; data_count_w=29 -> wr=1.
REQ-037 Early drop: requester 1 drops req after 2 acks -> release next edge, rr_ptr=2, requester 2 granted if requesting.
REQ-038 Reset mid-burst: rst=1 during requester 3 beat 3 -> next cycle grant=0, wr=0, beat_count=0; after rst=0 with req=1000|0001, requester 0 granted first.
